// File: rtl/ds1124_pkg.sv
// ============================================================================
// Module  : ds1124_pkg
// Purpose : Types and constants shared by the delay-sweep controller.
//           Holds the controller state encoding, the delay code width and
//           the sweep direction type.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ds1124_pkg;

  localparam int DELAY_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WAIT_WR = 3'd2,
    S_READ    = 3'd3,
    S_WAIT_RD = 3'd4,
    S_DWELL   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

`default_nettype wire

// File: rtl/ds1124_sweep_ctrl.sv
// ============================================================================
// Module  : ds1124_sweep_ctrl
// Purpose : Steps an external delay driver through a range of delay codes.
//           Each point is written (optionally read back and compared), then
//           held for a dwell period before moving to the next code.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ds1124_sweep_ctrl
  import ds1124_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] cfg_start,
  input  logic [DELAY_W-1:0] cfg_stop,
  input  logic [DELAY_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_verify,
  output logic [DELAY_W-1:0] drv_delay_value,
  output logic               drv_en,
  input  logic               drv_ready,
  output logic               drv_read_delay,
  input  logic [DELAY_W-1:0] drv_current_delay,
  input  logic               drv_read_valid,
  output logic               busy,
  output logic               step_strobe,
  output logic [DELAY_W-1:0] cur_delay,
  output logic               done,
  output logic               error
);

  // Wait timer is wide enough to hold TIMEOUT-1; it saturates there.
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   cur_q, cur_d;
  logic [DELAY_W-1:0]   stop_q, stop_d;
  logic [DELAY_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 verify_q, verify_d;
  dir_e                 dir_q, dir_d;
  logic                 error_q, error_d;
  logic                 abort_q, abort_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;

  logic                 abort_pend;
  logic                 tmr_expired;
  logic                 dwell_last;
  logic [DELAY_W:0]     nxt;
  logic                 sweep_end;

  // An abort arriving this cycle counts the same as one recorded earlier.
  assign abort_pend  = abort_q | abort;
  assign tmr_expired = (tmr_q >= TMR_LIM);
  assign dwell_last  = (dwell_cnt_q >= (dwell_q - DWELL_W'(1)));

  // Next code at one extra bit so leaving 0..255 shows up as carry/borrow.
  always_comb begin
    nxt       = '0;
    sweep_end = 1'b0;
    if (dir_q == DIR_UP) begin
      nxt       = {1'b0, cur_q} + {1'b0, step_q};
      sweep_end = (nxt > {1'b0, stop_q});
    end else begin
      nxt       = {1'b0, cur_q} - {1'b0, step_q};
      sweep_end = nxt[DELAY_W] || (nxt[DELAY_W-1:0] < stop_q);
    end
  end

  // Next-state logic: sequencing of write, optional readback and dwell.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    verify_d    = verify_q;
    dir_d       = dir_q;
    error_d     = error_q;
    abort_d     = (state_q == S_IDLE) ? 1'b0 : abort_pend;
    dwell_cnt_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cur_d    = cfg_start;
          stop_d   = cfg_stop;
          step_d   = (cfg_step == '0) ? DELAY_W'(1) : cfg_step;
          dwell_d  = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
          verify_d = cfg_verify;
          dir_d    = (cfg_start <= cfg_stop) ? DIR_UP : DIR_DOWN;
          error_d  = 1'b0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (drv_ready) begin
          state_d = S_WAIT_WR;
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_WR: begin
        // The driver may still show ready in the cycle right after the strobe.
        if ((tmr_q != '0) && drv_ready) begin
          if (abort_pend)    state_d = S_DONE;
          else if (verify_q) state_d = S_READ;
          else               state_d = S_DWELL;
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_READ: begin
        if (drv_ready) begin
          state_d = S_WAIT_RD;
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_RD: begin
        if (drv_read_valid) begin
          if (drv_current_delay != cur_q) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (abort_pend) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DWELL;
          end
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DWELL: begin
        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        if (abort_pend) begin
          state_d = S_DONE;
        end else if (dwell_last) begin
          if (sweep_end) begin
            state_d = S_DONE;
          end else begin
            cur_d   = nxt[DELAY_W-1:0];
            state_d = S_WRITE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timer restarts on every state change and saturates at its limit.
    if (state_d != state_q) tmr_d = '0;
    else if (tmr_expired)   tmr_d = tmr_q;
    else                    tmr_d = tmr_q + TMR_W'(1);
  end

  // State, latched configuration and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      verify_q    <= 1'b0;
      dir_q       <= DIR_UP;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
      dwell_cnt_q <= '0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      verify_q    <= verify_d;
      dir_q       <= dir_d;
      error_q     <= error_d;
      abort_q     <= abort_d;
      dwell_cnt_q <= dwell_cnt_d;
      tmr_q       <= tmr_d;
    end
  end

  // Strobes decode straight from state so reset removes them at once.
  assign drv_en          = (state_q == S_WRITE) && drv_ready;
  assign drv_read_delay  = (state_q == S_READ) && drv_ready;
  assign drv_delay_value = cur_q;
  assign cur_delay       = cur_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign step_strobe     = (state_q == S_DWELL) && (dwell_cnt_q == '0);
  assign error           = error_q;

endmodule

`default_nettype wire

// File: doc/ds1124_sweep_ctrl.md
DS1124_SWEEP_CTRL -- requirements
Module: ds1124_sweep_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: max cycles waiting on any driver response.
REQ-002 SHALL have parameter DWELL_W, default 16: dwell counter width.
REQ-003 SHALL have ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle sweep request
- abort  in  1  one-cycle stop request
- cfg_start  in  8  first delay code
- cfg_stop  in  8  last delay code bound
- cfg_step  in  8  step magnitude; 0 treated as 1
- cfg_dwell  in  DWELL_W  cycles per point; 0 treated as 1
- cfg_verify  in  1  read back each written code
- drv_delay_value  out  8  code to driver
- drv_en  out  1  driver write strobe
- drv_ready  in  1  driver idle
- drv_read_delay  out  1  driver read strobe
- drv_current_delay  in  8  driver readback data
- drv_read_valid  in  1  readback data valid
- busy  out  1  sweep in progress
- step_strobe  out  1  pulse: new point settled
- cur_delay  out  8  code of current point
- done  out  1  pulse: sweep ended
- error  out  1  sticky verify mismatch or timeout

Function
REQ-004 SHALL, when start=1 in IDLE, latch all cfg_* inputs; start while busy SHALL be ignored.
REQ-005 SHALL use states IDLE, WRITE, WAIT_WR, READ, WAIT_RD, DWELL, DONE.
REQ-006 SHALL, in WRITE, drive drv_delay_value=cur_delay and pulse drv_en for exactly one cycle, only when drv_ready=1.
REQ-007 SHALL, in WAIT_WR, ignore drv_ready during the first cycle after drv_en, then wait for drv_ready=1; next state is READ if verify is latched, else DWELL.
REQ-008 SHALL, in READ, pulse drv_read_delay for one cycle when drv_ready=1; in WAIT_RD, wait for drv_read_valid.
REQ-009 SHALL, on drv_read_valid with drv_current_delay != cur_delay, set error and go to DONE.
REQ-010 SHALL, if any WAIT_* or wait-for-ready exceeds TIMEOUT cycles, set error and go to DONE.
REQ-011 SHALL pulse step_strobe on the first DWELL cycle and hold DWELL for max(cfg_dwell,1) cycles.
REQ-012 SHALL sweep ascending if cfg_start<=cfg_stop, else descending; next = cur ± step, computed at 9 bits.
REQ-013 SHALL end the sweep (go to DONE) when the next value passes cfg_stop or leaves 0..255; stop is visited only if hit exactly.
REQ-014 SHALL record abort in any non-IDLE state; it is honoured only on leaving WAIT_WR/WAIT_RD or in DWELL, so no driver transaction is cut; then go to DONE.
REQ-015 SHALL make DONE last one cycle, pulse done, then return to IDLE.
REQ-016 SHALL clear error on an accepted start; otherwise error holds.
REQ-017 SHALL keep busy=1 in every state except IDLE.
REQ-018 SHALL give priority to abort when abort and start arrive in the same cycle in IDLE: nothing happens.

Reset
REQ-019 SHALL, on rst_n=0, asynchronously enter IDLE and set all outputs, counters and latched config to 0.
REQ-020 SHALL, on reset mid-transaction, drop drv_en/drv_read_delay immediately; the driver is reset by the same rst_n.

Structure
REQ-021 SHALL place the state enum, DELAY_W=8 and the step-direction type in shared package ds1124_pkg.
REQ-022 SHALL be a single module with no sub-modules; the ds1124_driver instance stays external, in the parent.

Verification
REQ-023 start=10, stop=30, step=10, dwell=3, verify=0 -> writes 10, 20, 30; 3 step_strobes; done; error=0.
REQ-024 start=250, stop=255, step=4 -> writes 250, 254 only; no wrap; done.
REQ-025 start=40, stop=20, step=0 -> 21 descending writes, 40..20.
REQ-026 verify=1, model returns code^1 on second point -> error=1 after second read; done; no third write.
REQ-027 Model holds drv_ready=0 forever -> error and done after TIMEOUT cycles.
REQ-028 abort during WAIT_WR of point 2 -> write completes; no DWELL; done next; busy drops; rst_n pulse mid-sweep -> all outputs 0.
